cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
- Synthesizable run controller and monitor that sits between the board/bench clock and the ARM LEGv8 pipelined core.
- Sequences the core's reset, runs the program, and detects completion by a HLT instruction, a stalled PC, or a cycle-budget timeout.
- Accumulates a data-memory write signature plus access counters, so programs are checked by comparing a few values instead of inspecting waveforms.

Parameters:
- ADDR_W, 64, PC and data-memory address width
- DATA_W, 64, data-memory write-data width; also the signature width
- INSTR_W, 32, instruction width
- RESET_CYCLES, 2, cycles cpu_reset is held in HOLD (≥1)
- MAX_CYCLES, 1000, RUN-cycle budget before timeout (≥1)
- HALT_STABLE, 4, consecutive unchanged-PC cycles that count as halt (≥1)
- HALT_INSTR, 32'hD4400000, instruction encoding treated as halt (HLT #0)
- CNT_W, 32, width of cycle_count
- ACC_W, 16, width of write_count and read_count

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- pc  in  ADDR_W  core PC
- instr  in  INSTR_W  instruction at pc
- mem_address  in  ADDR_W  core data-memory address
- mem_data_in  in  DATA_W  core write data
- mem_write  in  1  core memwrite strobe
- mem_read  in  1  core memread strobe
- cpu_reset  out  1  reset driven to the core
- running  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  valid with done; 1 means the budget was exhausted
- cycle_count  out  CNT_W  RUN cycles elapsed
- write_count  out  ACC_W  RUN-cycle writes, saturating
- read_count  out  ACC_W  RUN-cycle reads, saturating
- signature  out  DATA_W  write signature
- halt_pc  out  ADDR_W  PC captured on entry to DONE

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE; cpu_reset = 1.
  - running, done, timeout = 0.
  - All counters, signature and halt_pc = 0.
- RESET mid-run returns the block to IDLE with the reset values above on the next edge.
- FSM states: IDLE, HOLD, RUN, DONE.
- IDLE:
  - cpu_reset = 1.
  - start = 1 moves to HOLD next cycle and clears counters, signature, halt_pc, timeout and the stable tracker.
- HOLD:
  - cpu_reset = 1 for exactly RESET_CYCLES cycles, then RUN.
  - start is ignored.
- RUN:
  - cpu_reset = 0, running = 1.
  - cycle_count increments by 1 every RUN cycle, including the first.
  - start is ignored.
- DONE:
  - cpu_reset = 1 (core frozen), done = 1.
  - All results hold.
  - start = 1 restarts exactly as from IDLE.
- Monitoring happens only in RUN cycles; strobes in other states are ignored.
  - mem_write: write_count++ (saturating at all-ones); signature <= rotl1(signature) ^ mem_address ^ mem_data_in. When ADDR_W ≠ DATA_W, mem_address is zero-extended or truncated to DATA_W.
  - mem_read: read_count++ (saturating).
  - Both strobes high: both updates occur.
- Halt conditions, evaluated each RUN cycle:
  - (a) instr == HALT_INSTR.
  - (b) pc == pc_prev for HALT_STABLE consecutive RUN cycles. The first RUN cycle has no valid pc_prev and never counts. Any PC change resets the tracker to 0.
- Timeout: cycle_count reaches MAX_CYCLES on this cycle.
- Any condition true moves to DONE next cycle; halt_pc <= pc.
  - timeout = 1 only if the budget condition fired and no halt condition did. Halt wins a tie.
  - The monitoring updates of the terminating cycle are still applied.

Decomposition:
- Shared package cpu_run_pkg holds:
  - the state enum (IDLE, HOLD, RUN, DONE)
  - HLT_ENCODING = 32'hD4400000
  - the rotl1 function
- One natural sub-module: run_signature_misr (DATA_W parameter; inputs CLOCK, RESET, clr, en, addr, data; output sig), reused by later multi-core benches.
- The FSM and counters stay in the top.

Test Plan:
- Reset: hold RESET 3 cycles with start = 1 -> cpu_reset = 1, running = 0, done = 0, all counts and signature = 0, state stays IDLE.
- Start sequencing, RESET_CYCLES = 2: pulse start -> cpu_reset high for 2 further cycles, then cpu_reset = 0 and running = 1; cycle_count = 1 on the first RUN cycle.
- HLT halt: pc increments by 4 from 0, instr = D4400000 on the 5th RUN cycle at pc = 0x10 -> done = 1, timeout = 0, cycle_count = 5, halt_pc = 0x10, cpu_reset = 1.
- Stable PC, HALT_STABLE = 4: pc goes 0, 4, then stays 0x20 -> DONE after the 4th repeat of 0x20, halt_pc = 0x20; a PC blip inside the window restarts the count.
- Timeout, MAX_CYCLES = 16, pc always changing:
  - Result: done with timeout = 1 and cycle_count = 16.
  - Repeat with HLT on cycle 16: timeout = 0.
- Signature:
  - From sig = 0, writes (addr 0x8, data 0x5) then (addr 0x10, data 0xB) -> sig 0xD, then 0x1, with write_count = 2.
  - A mem_write in HOLD or DONE leaves sig and the count unchanged.
  - Restart from DONE clears sig and the counters.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the LEGv8 run controller and its signature MISR.
`timescale 1ns/1ps
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam logic [31:0] HLT_ENCODING = 32'hD4400000;

    // Widest value rotl1 can handle; callers pass the width actually in use.
    localparam int ROT_MAX_W = 256;

    function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                   input int unsigned           w);
        logic [ROT_MAX_W-1:0] mask;
        logic [ROT_MAX_W-1:0] vm;
        mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
        vm   = v & mask;
        return ((vm << 1) | (vm >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/run_signature_misr.sv
// Rotate-and-xor signature register folding each enabled (addr, data) pair.
`timescale 1ns/1ps
module run_signature_misr
    import cpu_run_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sig
);

    logic [DATA_W-1:0] rot;

    always_comb begin
        rot = DATA_W'(rotl1(ROT_MAX_W'(sig), DATA_W));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= rot ^ addr ^ data;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences core reset, runs a program until HLT / stalled PC / timeout, and
// records cycle, access counts and a write signature for quick result checks.
`timescale 1ns/1ps
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int                   ADDR_W       = 64,
    parameter int                   DATA_W       = 64,
    parameter int                   INSTR_W      = 32,
    parameter int                   RESET_CYCLES = 2,
    parameter int                   MAX_CYCLES   = 1000,
    parameter int                   HALT_STABLE  = 4,
    parameter logic [INSTR_W-1:0]   HALT_INSTR   = INSTR_W'(HLT_ENCODING),
    parameter int                   CNT_W        = 32,
    parameter int                   ACC_W        = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [DATA_W-1:0]  mem_data_in,
    input  logic               mem_write,
    input  logic               mem_read,
    output logic               cpu_reset,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [ACC_W-1:0]   write_count,
    output logic [ACC_W-1:0]   read_count,
    output logic [DATA_W-1:0]  signature,
    output logic [ADDR_W-1:0]  halt_pc
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int STAB_W = $clog2(HALT_STABLE + 1);

    run_state_t        state, state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STAB_W-1:0] stable_cnt, stable_next;
    logic [ADDR_W-1:0] pc_prev;
    logic              pc_valid;
    logic              start_ok, pc_same, stable_hit, halt_hit, budget_hit, finish;
    logic              sig_en;
    logic [DATA_W-1:0] addr_fold;

    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_next  = state;
        start_ok    = 1'b0;
        finish      = 1'b0;
        pc_same     = pc_valid && (pc == pc_prev);
        stable_next = pc_same ? stable_cnt + 1'b1 : '0;
        stable_hit  = pc_same && (stable_next >= STAB_W'(HALT_STABLE));
        halt_hit    = (instr == HALT_INSTR) || stable_hit;
        // cycle_count already shows the current RUN cycle's index
        budget_hit  = (cycle_count == CNT_W'(MAX_CYCLES));
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = HOLD;
                    start_ok   = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_next = RUN;
            end
            RUN: begin
                finish = halt_hit || budget_hit;
                if (finish) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            write_count <= '0;
            read_count  <= '0;
            halt_pc     <= '0;
            hold_cnt    <= '0;
            stable_cnt  <= '0;
            pc_prev     <= '0;
            pc_valid    <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != RUN);
            running   <= (state_next == RUN);
            done      <= (state_next == DONE);

            if (start_ok) begin
                cycle_count <= '0;
                write_count <= '0;
                read_count  <= '0;
                halt_pc     <= '0;
                timeout     <= 1'b0;
                hold_cnt    <= '0;
                stable_cnt  <= '0;
                pc_valid    <= 1'b0;
            end

            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (state_next == RUN) cycle_count <= CNT_W'(1);
            end

            if (state == RUN) begin
                pc_prev    <= pc;
                pc_valid   <= 1'b1;
                stable_cnt <= stable_next;
                if (mem_write) write_count <= sat_inc(write_count);
                if (mem_read)  read_count  <= sat_inc(read_count);
                if (finish) begin
                    halt_pc <= pc;
                    timeout <= budget_hit && !halt_hit;
                end else begin
                    cycle_count <= cycle_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_fold = DATA_W'(mem_address);
        sig_en    = (state == RUN) && mem_write;
    end

    run_signature_misr #(
        .DATA_W (DATA_W)
    ) u_misr (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clr   (start_ok),
        .en    (sig_en),
        .addr  (addr_fold),
        .data  (mem_data_in),
        .sig   (signature)
    );

endmodule
